// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_res  = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_res <= w_res;
          r_cnt <= r_cnt + CW'(1);
          // Final bit: publish result in the same edge that enters DONE
          if (w_last) begin
            r_sum   <= w_res;
            r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= r_c ^ w_c;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Reference: {cout,sum} = a + b + cin computed with plain arithmetic.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
  logic       prev_ovf = 1'b0;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] prev_sum = '0;
  logic       prev_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x,
                                   input logic [7:0] y,
                                   input logic [7:0] s);
    return (x[7] == y[7]) && (s[7] != x[7]);
  endfunction

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input bit poke);
    logic [8:0] exp;
    int lat;
    int nbusy;
    bit seen;
    bit hold_ok;
    exp = ref_add(ia, ib, ic);
    @(negedge clk);
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    lat = 0;
    nbusy = 0;
    seen = 0;
    hold_ok = 1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
      end
      if (poke && lat == 3) begin
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
      end
      if (poke && lat == 4) start = 1'b0;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) seen = 1;
      else if (sum !== prev_sum || cout !== prev_cout) hold_ok = 0;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", lat, 9);
    chk("busy_cycles", nbusy, 8);
    chk("sum_hold", 32'(hold_ok), 32'd1);
    chk("sum", 32'(sum), 32'(exp[7:0]));
    chk("cout", 32'(cout), 32'(exp[8]));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(ref_ovf(ia, ib, exp[7:0])));
    prev_ovf = ref_ovf(ia, ib, exp[7:0]);
`endif
    prev_sum = exp[7:0];
    prev_cout = exp[8];
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int d1;
    int d2;
    bit gap;
    bit saw;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h3C, 8'h0F, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h12, 8'h34, 1'b0, 1);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    cin = 1'b0;
    start = 1'b1;
    lat = 0;
    d1 = 0;
    d2 = 0;
    gap = 0;
    while (d2 == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        a = 8'h10;
        b = 8'h20;
      end
      if (done === 1'b1) begin
        if (d1 == 0) begin
          d1 = lat;
          chk("b2b_sum1", 32'(sum), 32'h03);
          chk("b2b_cout1", 32'(cout), 32'd0);
        end else begin
          d2 = lat;
          chk("b2b_sum2", 32'(sum), 32'h30);
          start = 1'b0;
        end
      end else if (d1 != 0 && busy !== 1'b1) begin
        gap = 1;
      end
    end
    chk("b2b_first", d1, 9);
    chk("b2b_spacing", d2 - d1, 9);
    chk("b2b_nogap", 32'(gap), 32'd0);
    prev_sum = 8'h30;
    prev_cout = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 8'hF0;
    b = 8'h0F;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    saw = 0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) saw = 1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) saw = 1;
    end
    chk("abort_no_done", 32'(saw), 32'd0);
    prev_sum = '0;
    prev_cout = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), (i % 7) == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
